noc_outport_ctrl: RTL

- Per-output-port controller for the 5-port mesh router.
- Arbitrates round-robin among input ports requesting this output and locks the winner for a full wormhole packet of PKT_FLITS flits.
- Tracks downstream buffer credits and generates the crossbar select, the input-buffer pop strobes and the output flit-valid.
- One instance per output port (N, S, E, W, Local), between the input buffers and the crossbar.

---
 rtl/noc_outport_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/noc_outport_ctrl.sv
// Output-port controller for the 5-port mesh router: round-robin arbitration with
// wormhole lock, downstream credit tracking, crossbar select and input-buffer pops.
module noc_outport_ctrl #(
   parameter int N_IN      = 5,
   parameter int PKT_FLITS = 5,
   parameter int CREDITS   = 4,
   parameter int CW        = $clog2(CREDITS+1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_IN-1:0] req_i,
   input  logic [N_IN-1:0] flit_valid_i,
   input  logic            credit_ret_i,
   output logic [N_IN-1:0] grant_o,
   output logic [2:0]      sel_o,
   output logic [N_IN-1:0] pop_o,
   output logic            out_valid_o,
   output logic            busy_o,
   output logic [CW-1:0]   credits_o,
   output logic            credit_err_o
);

   typedef enum logic {IDLE, XFER} state_t;

   localparam logic [N_IN-1:0] ONE_HOT0 = {{(N_IN-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]   CRED_MAX = CW'(CREDITS);
   localparam logic [CW-1:0]   CRED_ONE = CW'(1);
   localparam logic [3:0]      LAST_CNT = 4'(PKT_FLITS-1);
   localparam logic [2:0]      LAST_IDX = 3'(N_IN-1);

   state_t          state_q;
   logic [N_IN-1:0] grant_q;
   logic [2:0]      sel_q;
   logic [2:0]      rr_q;
   logic [3:0]      cnt_q;
   logic [CW-1:0]   credits_q;
   logic            err_q;

   logic            any_req;
   logic [2:0]      pick;
   logic [3:0]      scan_idx;
   logic            transfer;
   logic            tail;

   // First requester at or above the rr pointer, wrapping past N_IN-1 back to 0.
   always_comb begin
      any_req  = 1'b0;
      pick     = 3'd0;
      scan_idx = 4'd0;
      for (int k = 0; k < N_IN; k++) begin
         scan_idx = {1'b0, rr_q} + 4'(k);
         if (scan_idx >= 4'(N_IN)) scan_idx = scan_idx - 4'(N_IN);
         if (!any_req && |(req_i & (ONE_HOT0 << scan_idx))) begin
            any_req = 1'b1;
            pick    = scan_idx[2:0];
         end
      end
   end

   // A flit moves when the granted buffer has one (valid) and downstream has space
   // (ready = credit available); pop_o and out_valid_o both fire in that same cycle.
   assign transfer = (state_q == XFER) && !rst && |(flit_valid_i & grant_q)
                     && (credits_q != '0);
   assign tail     = transfer && (cnt_q == LAST_CNT);

   always_comb begin
      pop_o = '0;
      if (transfer) pop_o = grant_q;
   end

   assign out_valid_o  = transfer;
   assign grant_o      = grant_q;
   assign sel_o        = sel_q;
   assign busy_o       = (state_q == XFER);
   assign credits_o    = credits_q;
   assign credit_err_o = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= 3'b111;
         rr_q    <= 3'd0;
         cnt_q   <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  state_q <= XFER;
                  grant_q <= ONE_HOT0 << pick;
                  sel_q   <= pick;
                  cnt_q   <= 4'd0;
               end
            end
            XFER: begin
               if (tail) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  sel_q   <= 3'b111;
                  rr_q    <= (sel_q == LAST_IDX) ? 3'd0 : sel_q + 3'd1;
                  cnt_q   <= 4'd0;
               end else if (transfer) begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A simultaneous return and transfer cancel out; a return into a full counter is an error.
   always_ff @(posedge clk) begin
      if (rst) begin
         credits_q <= CRED_MAX;
         err_q     <= 1'b0;
      end else if (transfer && !credit_ret_i) begin
         credits_q <= credits_q - CRED_ONE;
      end else if (!transfer && credit_ret_i) begin
         if (credits_q == CRED_MAX) err_q <= 1'b1;
         else                       credits_q <= credits_q + CRED_ONE;
      end
   end

endmodule
